// File: rtl/spec_thresh_pkg.sv
// rtl/spec_thresh_pkg.sv - shared width helpers, FSM states and err bit positions
package spec_thresh_pkg;

  function automatic int mag_w(input int data_w);
    return 2 * data_w + 1;
  endfunction

  function automatic int sq_w(input int data_w);
    return 2 * data_w;
  endfunction

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} state_e;

  localparam int ERR_NFFT = 0;
  localparam int ERR_SEQ  = 1;

endpackage

// File: rtl/mag_sq_pipe.sv
// rtl/mag_sq_pipe.sv - two-stage signed square-and-sum with aligned valid/index sideband
module mag_sq_pipe
  import spec_thresh_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  IDX_W  = 10,
  localparam int MAG_W  = mag_w(DATA_W),
  localparam int SQ_W   = sq_w(DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [IDX_W-1:0]         in_index,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  output logic [IDX_W-1:0]         out_index,
  output logic [MAG_W-1:0]         out_mag
);
  logic                     v1_q, v1_d, v2_q, v2_d;
  logic [IDX_W-1:0]         i1_q, i1_d, i2_q, i2_d;
  logic signed [DATA_W-1:0] re1_q, re1_d, im1_q, im1_d;
  logic signed [SQ_W-1:0]   re_ext, im_ext;
  logic [SQ_W-1:0]          sqr_q, sqr_d, sqi_q, sqi_d;

  always_comb begin
    v1_d   = in_valid;
    i1_d   = in_index;
    re1_d  = in_re;
    im1_d  = in_im;
    re_ext = SQ_W'(re1_q);
    im_ext = SQ_W'(im1_q);
    // Largest square is 2^(2*DATA_W-2), so the unsigned view of the product is exact
    sqr_d  = re_ext * re_ext;
    sqi_d  = im_ext * im_ext;
    v2_d   = v1_q;
    i2_d   = i1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      i1_q  <= '0;
      re1_q <= '0;
      im1_q <= '0;
      v2_q  <= 1'b0;
      i2_q  <= '0;
      sqr_q <= '0;
      sqi_q <= '0;
    end else begin
      v1_q  <= v1_d;
      i1_q  <= i1_d;
      re1_q <= re1_d;
      im1_q <= im1_d;
      v2_q  <= v2_d;
      i2_q  <= i2_d;
      sqr_q <= sqr_d;
      sqi_q <= sqi_d;
    end
  end

  assign out_valid = v2_q;
  assign out_index = i2_q;
  assign out_mag   = MAG_W'(sqr_q) + MAG_W'(sqi_q);

endmodule

// File: rtl/spectrum_threshold_engine.sv
// rtl/spectrum_threshold_engine.sv - |X|^2 thresholding into mag and bitmap RAMs
// Optional peak-hold read-modify-write of the mag RAM is enabled by defining PEAK_HOLD_EN.
module spectrum_threshold_engine
  import spec_thresh_pkg::*;
#(
  parameter int  DATA_W   = 16,
  parameter int  MAX_LOG2 = 10,
  parameter int  MIN_LOG2 = 3,
  parameter int  WORD_W   = 32,
  localparam int MAG_W    = mag_w(DATA_W),
  localparam int WL       = $clog2(WORD_W),
  localparam int BM_AW    = MAX_LOG2 - WL
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [4:0]               nfft_log2,
  input  logic [MAG_W-1:0]         threshold,
  input  logic                     peak_clr,
  input  logic                     in_valid,
  input  logic [MAX_LOG2-1:0]      in_index,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  input  logic [MAX_LOG2-1:0]      mag_rd_addr,
  output logic [MAG_W-1:0]         mag_rd_data,
  input  logic [BM_AW-1:0]         bm_rd_addr,
  output logic [WORD_W-1:0]        bm_rd_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic [MAX_LOG2:0]        hit_count,
  output logic [1:0]               err
);
  state_e              state_q, state_d;
  logic [MAX_LOG2-1:0] exp_q, exp_d, last_q, last_d;
  logic [MAG_W-1:0]    thr_q, thr_d;
  logic [1:0]          err_q, err_d;
  logic                fd_q, fd_d;
  logic [MAX_LOG2:0]   hit_q, hit_d, hacc_q, hacc_d, hacc_new;
  logic [WORD_W-1:0]   acc_q, acc_d, acc_new;
  logic                nfft_ok, accept;
  logic                s3_valid, s3_hit, s3_last, bm_we;
  logic [MAX_LOG2-1:0] s3_idx, mag_ra;
  logic [WL-1:0]       s3_pos;
  logic [MAG_W-1:0]    s3_mag, mag_wd, mag_rd_q;
  logic [WORD_W-1:0]   bm_rd_q;
  logic [MAG_W-1:0]    mag_mem [2**MAX_LOG2];
  logic [WORD_W-1:0]   bm_mem  [2**BM_AW];

  assign nfft_ok = (int'(nfft_log2) >= MIN_LOG2) && (int'(nfft_log2) <= MAX_LOG2);
  assign accept  = in_valid && ((state_q == ARMED && in_index == '0) ||
                                (state_q == CAPTURE && in_index == exp_q));

  mag_sq_pipe #(.DATA_W(DATA_W), .IDX_W(MAX_LOG2)) u_mag_sq_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (accept),
    .in_index (in_index),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(s3_valid),
    .out_index(s3_idx),
    .out_mag  (s3_mag)
  );

  always_comb begin
    s3_pos   = s3_idx[WL-1:0];
    s3_last  = (s3_idx == last_q);
    s3_hit   = s3_valid && (s3_mag > thr_q);
    // Bin 0 restarts accumulation, so in-flight samples of an aborted frame cannot leak forward
    acc_new  = ((s3_idx == '0) ? '0 : acc_q) | (WORD_W'(s3_hit) << s3_pos);
    hacc_new = ((s3_idx == '0) ? '0 : hacc_q) + (MAX_LOG2+1)'(s3_hit);
    bm_we    = s3_valid && ((s3_pos == WL'(WORD_W - 1)) || s3_last);
    acc_d    = s3_valid ? (bm_we ? '0 : acc_new) : acc_q;
    hacc_d   = s3_valid ? hacc_new : hacc_q;

    state_d = state_q;
    exp_d   = exp_q;
    last_d  = last_q;
    thr_d   = thr_q;
    err_d   = err_q;
    fd_d    = 1'b0;
    hit_d   = hit_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (nfft_ok) begin
            state_d = ARMED;
            err_d   = '0;
            thr_d   = threshold;
            last_d  = MAX_LOG2'((32'd1 << nfft_log2) - 32'd1);
          end else begin
            err_d[ERR_NFFT] = 1'b1;
          end
        end
      end
      ARMED: begin
        if (accept) begin
          state_d = CAPTURE;
          exp_d   = MAX_LOG2'(1);
        end
      end
      CAPTURE: begin
        if (in_valid) begin
          if (accept) begin
            exp_d = exp_q + MAX_LOG2'(1);
            if (in_index == last_q) state_d = FLUSH;
          end else begin
            err_d[ERR_SEQ] = 1'b1;
            state_d        = IDLE;
          end
        end
      end
      FLUSH: begin
        if (s3_valid && s3_last) begin
          state_d = IDLE;
          fd_d    = 1'b1;
          hit_d   = hacc_new;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PEAK_HOLD_EN
  logic [MAG_W-1:0] pk_q, pk_d;
  logic             pclr_q, pclr_d;

  // Capture read is issued at S0 and shares the host port; its data lands in pk_q by S3
  assign mag_ra = accept ? in_index : mag_rd_addr;

  always_comb begin
    pk_d   = mag_rd_q;
    pclr_d = pclr_q;
    if (peak_clr && (state_q == IDLE || state_q == ARMED)) pclr_d = 1'b1;
    if (fd_d) pclr_d = 1'b0;
    mag_wd = (pclr_q || (s3_mag > pk_q)) ? s3_mag : pk_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_q   <= '0;
      pclr_q <= 1'b0;
    end else begin
      pk_q   <= pk_d;
      pclr_q <= pclr_d;
    end
  end
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign mag_ra          = mag_rd_addr;
  assign mag_wd          = s3_mag;
`endif

  always_ff @(posedge clk) begin
    if (s3_valid) mag_mem[s3_idx] <= mag_wd;
    if (bm_we) bm_mem[s3_idx[MAX_LOG2-1:WL]] <= acc_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_rd_q <= '0;
      bm_rd_q  <= '0;
    end else begin
      mag_rd_q <= mag_mem[mag_ra];
      bm_rd_q  <= bm_mem[bm_rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
      last_q  <= '0;
      thr_q   <= '0;
      err_q   <= '0;
      fd_q    <= 1'b0;
      hit_q   <= '0;
      hacc_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      last_q  <= last_d;
      thr_q   <= thr_d;
      err_q   <= err_d;
      fd_q    <= fd_d;
      hit_q   <= hit_d;
      hacc_q  <= hacc_d;
      acc_q   <= acc_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign frame_done  = fd_q;
  assign hit_count   = hit_q;
  assign err         = err_q;
  assign mag_rd_data = mag_rd_q;
  assign bm_rd_data  = bm_rd_q;

endmodule

// File: tb/tb_spectrum_threshold_engine.sv
// tb/tb_spectrum_threshold_engine.sv - scoreboard bench for spectrum_threshold_engine
module tb_spectrum_threshold_engine;
  localparam int DATA_W = 16, MAX_LOG2 = 10, WORD_W = 32, MAG_W = 33, BM_AW = 5;

  logic clk = 0, rst_n = 0, start = 0, peak_clr = 0, in_valid = 0;
  logic [4:0] nfft_log2 = '0;
  logic [MAG_W-1:0] threshold = '0;
  logic [MAX_LOG2-1:0] in_index = '0, mag_rd_addr = '0;
  logic signed [DATA_W-1:0] in_re = '0, in_im = '0;
  logic [BM_AW-1:0] bm_rd_addr = '0;
  logic [MAG_W-1:0] mag_rd_data;
  logic [WORD_W-1:0] bm_rd_data;
  logic busy, frame_done;
  logic [MAX_LOG2:0] hit_count;
  logic [1:0] err;

  int checks = 0, errors = 0;
  int cyc = 0, fd_seen = 0, fd_cyc = 0;
  logic rd_req = 0, rd_pend = 0;
  bit auto_clr = 1;

  typedef struct {
    bit               is_bm;
    logic [MAG_W-1:0] val;
    string            name;
  } rd_exp_t;
  rd_exp_t rd_sb[$];
  int      fd_sb[$];

  logic [MAG_W-1:0]  ref_mag[1024];
  logic [WORD_W-1:0] ref_bm[32];
  int re_v[1024], im_v[1024];

  spectrum_threshold_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nfft_log2(nfft_log2), .threshold(threshold),
    .peak_clr(peak_clr), .in_valid(in_valid), .in_index(in_index), .in_re(in_re), .in_im(in_im),
    .mag_rd_addr(mag_rd_addr), .mag_rd_data(mag_rd_data), .bm_rd_addr(bm_rd_addr),
    .bm_rd_data(bm_rd_data), .busy(busy), .frame_done(frame_done), .hit_count(hit_count), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_req;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a read result or frame_done appears
  initial forever begin
    rd_exp_t e;
    @(negedge clk);
    if (rd_pend) begin
      if (rd_sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got read result with empty scoreboard");
      end else begin
        e = rd_sb.pop_front();
        check(e.name, e.is_bm ? 64'(bm_rd_data) : 64'(mag_rd_data), 64'(e.val));
      end
    end
    if (frame_done === 1'b1) begin
      fd_seen++;
      fd_cyc = cyc;
      if (fd_sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame_done: got pulse (hit_count=%0d), required none", hit_count);
      end else begin
        check("hit_count", 64'(hit_count), 64'(fd_sb.pop_front()));
      end
    end
  end

  task automatic drive(input logic v, input int idx, input int re, input int im);
    @(posedge clk); #1;
    in_valid = v; in_index = MAX_LOG2'(idx); in_re = DATA_W'(re); in_im = DATA_W'(im);
    start = 0; rd_req = 0; peak_clr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  task automatic do_start(input int nl, input logic [MAG_W-1:0] thr);
    @(posedge clk); #1;
    in_valid = 0; rd_req = 0; start = 1; nfft_log2 = 5'(nl); threshold = thr; peak_clr = auto_clr;
    @(posedge clk); #1;
    start = 0; peak_clr = 0;
  endtask

  task automatic rd_mag(input int a, input logic [MAG_W-1:0] v, input string nm);
    rd_exp_t e;
    @(posedge clk); #1;
    in_valid = 0; start = 0; mag_rd_addr = MAX_LOG2'(a); rd_req = 1;
    e.is_bm = 0; e.val = v; e.name = nm;
    rd_sb.push_back(e);
  endtask

  task automatic rd_bm(input int a, input logic [WORD_W-1:0] v, input string nm);
    rd_exp_t e;
    @(posedge clk); #1;
    in_valid = 0; start = 0; bm_rd_addr = BM_AW'(a); rd_req = 1;
    e.is_bm = 1; e.val = MAG_W'(v); e.name = nm;
    rd_sb.push_back(e);
  endtask

  task automatic wait_fd(input int seen0, input int last_cyc, input string nm);
    int t = 0;
    int lat;
    while (fd_seen == seen0 && t < 40) begin
      @(posedge clk); t++;
    end
    check({nm, "_frame_done_count"}, 64'(fd_seen - seen0), 64'd1);
    if (fd_seen != seen0) begin
      lat = fd_cyc - last_cyc;
      checks++;
      if (lat < 3 || lat > 4) begin
        errors++;
        $display("FAIL %s_latency: got %0d cycles, required 3..4", nm, lat);
      end
    end
  endtask

`ifdef PEAK_HOLD_EN
  task automatic peak_frame(input int v5, input string nm);
    int s0, lc;
    fd_sb.push_back(1);
    s0 = fd_seen;
    do_start(3, '0);
    for (int i = 0; i < 8; i++) drive(1, i, (i == 5) ? v5 : 0, 0);
    lc = cyc;
    drive(0, 0, 0, 0);
    wait_fd(s0, lc, nm);
  endtask
`endif

  initial begin
    int s0, lc, hits;
    longint m;

    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_mag_rd", 64'(mag_rd_data), 64'd0);
    check("rst_bm_rd", 64'(bm_rd_data), 64'd0);
    rst_n = 1;
    idle(2);

    // Out-of-range sizes
    do_start(11, '0);
    check("bad_nfft11_err", 64'(err), 64'd1);
    check("bad_nfft11_busy", 64'(busy), 64'd0);
    do_start(2, '0);
    check("bad_nfft2_err", 64'(err), 64'd1);
    check("bad_nfft2_busy", 64'(busy), 64'd0);

    // T1: re=index, threshold 100, junk samples before bin 0
    fd_sb.push_back(21);
    s0 = fd_seen;
    do_start(5, 33'd100);
    check("t1_err_clr", 64'(err), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    drive(1, 7, 500, 500);
    drive(1, 7, 500, 500);
    for (int i = 0; i < 32; i++) drive(1, i, i, 0);
    lc = cyc;
    drive(0, 0, 0, 0);
    wait_fd(s0, lc, "t1");
    check("t1_idle", 64'(busy), 64'd0);
    rd_mag(10, 33'd100, "t1_mag10");
    rd_mag(11, 33'd121, "t1_mag11");
    rd_mag(31, 33'd961, "t1_mag31");
    rd_mag(8, 33'd64, "t1_mag8");
    rd_bm(0, 32'hFFFF_F800, "t1_bm0");
    idle(2);

    // T2: full-scale negative samples, smallest size
    fd_sb.push_back(8);
    s0 = fd_seen;
    do_start(3, 33'd100);
    for (int i = 0; i < 8; i++) drive(1, i, -32768, -32768);
    lc = cyc;
    drive(0, 0, 0, 0);
    wait_fd(s0, lc, "t2");
    rd_mag(0, 33'h0_8000_0000, "t2_mag0");
    rd_mag(7, 33'h0_8000_0000, "t2_mag7");
    rd_mag(8, 33'd64, "t2_mag8_untouched");
    rd_bm(0, 32'h0000_00FF, "t2_bm0");
    idle(2);

    // T3: index sequence error
    do_start(5, 33'd100);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 2, 0, 0);
    drive(1, 4, 0, 0);
    idle(6);
    check("t3_err_seq", 64'(err), 64'd2);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_hit_held", 64'(hit_count), 64'd8);

    // T3b: valid start clears err; start during capture is ignored
    fd_sb.push_back(5);
    s0 = fd_seen;
    do_start(3, 33'd1000);
    check("t3b_err_clr", 64'(err), 64'd0);
    check("t3b_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) drive(1, i, 10 * i, 10 * i);
    do_start(11, '0);
    check("t4_start_busy_err", 64'(err), 64'd0);
    check("t4_start_busy_busy", 64'(busy), 64'd1);
    for (int i = 4; i < 8; i++) drive(1, i, 10 * i, 10 * i);
    lc = cyc;
    drive(0, 0, 0, 0);
    wait_fd(s0, lc, "t3b");
    rd_mag(3, 33'd1800, "t3b_mag3");
    rd_bm(0, 32'h0000_00F8, "t3b_bm0");
    idle(2);

    // T5: largest size with random gaps against a reference model
    hits = 0;
    for (int w = 0; w < 32; w++) ref_bm[w] = '0;
    for (int i = 0; i < 1024; i++) begin
      re_v[i] = int'($urandom_range(65535)) - 32768;
      im_v[i] = int'($urandom_range(65535)) - 32768;
      m = longint'(re_v[i]) * re_v[i] + longint'(im_v[i]) * im_v[i];
      ref_mag[i] = MAG_W'(m);
      if (m > 64'h2000_0000) begin
        hits++;
        ref_bm[i / 32][i % 32] = 1'b1;
      end
    end
    fd_sb.push_back(hits);
    s0 = fd_seen;
    do_start(10, 33'h0_2000_0000);
    for (int i = 0; i < 1024; i++) begin
      while ($urandom_range(1) == 1) drive(0, 0, 0, 0);
      drive(1, i, re_v[i], im_v[i]);
    end
    lc = cyc;
    drive(0, 0, 0, 0);
    wait_fd(s0, lc, "t5");
    for (int i = 0; i < 1024; i++) rd_mag(i, ref_mag[i], $sformatf("t5_mag%0d", i));
    for (int w = 0; w < 32; w++) rd_bm(w, ref_bm[w], $sformatf("t5_bm%0d", w));
    idle(2);

    // Reset mid-frame
    do_start(5, 33'd100);
    for (int i = 0; i < 10; i++) drive(1, i, 50, 50);
    @(posedge clk); #1;
    in_valid = 0;
    rst_n = 0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hit", 64'(hit_count), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    idle(6);

`ifdef PEAK_HOLD_EN
    peak_frame(30, "t6a");
    auto_clr = 0;
    peak_frame(20, "t6b");
    rd_mag(5, 33'd900, "t6_peak_held");
    idle(1);
    @(posedge clk); #1;
    peak_clr = 1;
    @(posedge clk); #1;
    peak_clr = 0;
    peak_frame(20, "t6c");
    rd_mag(5, 33'd400, "t6_peak_cleared");
    idle(2);
`endif

    idle(5);
    check("sb_rd_drained", 64'(rd_sb.size()), 64'd0);
    check("sb_fd_drained", 64'(fd_sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

endmodule
